mem_lsu: RTL

//  Parametrised MEM pipeline stage with a built-in Wishbone load/store master. Sits between EX and WB.

---
 rtl/mem_lsu.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/mem_lsu.sv
// ============================================================================
// Module   : mem_lsu
// Brief    : MEM pipeline stage with an integrated Wishbone load/store master.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_lsu #(
    parameter int ADDR_W  = 32,
    parameter int RD_W    = 5,
    parameter int TIMEOUT = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              mem_valid_i,
    input  logic [ADDR_W-1:0] mem_alu_i,
    input  logic [31:0]       mem_rsc2_i,
    input  logic [31:0]       mem_pc_i,
    input  logic [31:0]       mem_pc4_i,
    input  logic              mem_link_i,
    input  logic [RD_W-1:0]   mem_rd_i,
    input  logic              mem_we_i,
    input  logic              mem_re_i,
    input  logic [2:0]        mem_funct3_i,
    input  logic              mem_stall_i,
    output logic              mem_stall_o,
    output logic              mem_valid_o,
    output logic [31:0]       mem_out_o,
    output logic [RD_W-1:0]   mem_rd_o,
    output logic [31:0]       mem_pc_o,
    output logic              mem_exc_o,
    output logic [3:0]        mem_exc_code_o,
    output logic              wbs_cyc_o,
    output logic              wbs_stb_o,
    output logic              wbs_we_o,
    output logic [ADDR_W-1:0] wbs_addr_o,
    output logic [3:0]        wbs_sel_o,
    output logic [31:0]       wbs_dat_o,
    input  logic [31:0]       wbs_dat_i,
    input  logic              wbs_ack_i,
    input  logic              wbs_err_i
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] c_TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUS  = 1'b1
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_valid, r_exc, r_cyc, r_we, r_ld;
    logic [31:0]       r_out, r_pc, r_dat, r_alu32;
    logic [RD_W-1:0]   r_rd, r_mrd;
    logic [3:0]        r_code, r_sel;
    logic [ADDR_W-1:0] r_addr;
    logic [2:0]        r_f3;
    logic [1:0]        r_lane;

    logic              w_accept, w_is_mem, w_illegal, w_misal, w_trap, w_start;
    logic              w_timeout, w_fault, w_ok;
    logic [3:0]        w_trap_code, w_sel;
    logic [31:0]       w_alu32, w_dat, w_shift, w_ld;

    assign mem_stall_o = (r_state == S_BUS) | (r_valid & mem_stall_i);

    always_comb begin
        w_alu32     = 32'(mem_alu_i);
        w_accept    = (r_state == S_IDLE) & mem_valid_i & ~mem_stall_o;
        w_is_mem    = mem_we_i | mem_re_i;
        w_illegal   = mem_we_i ? (mem_funct3_i > 3'b010)
                               : ((mem_funct3_i == 3'b011) || (mem_funct3_i[2:1] == 2'b11));
        w_misal     = ((mem_funct3_i[1:0] == 2'b01) & mem_alu_i[0]) |
                      ((mem_funct3_i[1:0] == 2'b10) & (mem_alu_i[1:0] != 2'b00));
        w_trap      = w_is_mem & (w_illegal | w_misal);
        w_trap_code = w_illegal ? 4'd2 : (mem_we_i ? 4'd6 : 4'd4);
        w_start     = w_accept & w_is_mem & ~w_trap;
        w_timeout   = (TIMEOUT != 0) && (r_cnt == c_TO_LAST);
        // A fault (error or timeout) takes priority over a simultaneous ack.
        w_fault     = (r_state == S_BUS) & (wbs_err_i | w_timeout);
        w_ok        = (r_state == S_BUS) & wbs_ack_i & ~w_fault;

        case (mem_funct3_i[1:0])
            2'b00:   begin w_sel = 4'b0001 << mem_alu_i[1:0]; w_dat = {4{mem_rsc2_i[7:0]}};  end
            2'b01:   begin w_sel = 4'b0011 << mem_alu_i[1:0]; w_dat = {2{mem_rsc2_i[15:0]}}; end
            default: begin w_sel = 4'b1111;                   w_dat = mem_rsc2_i;            end
        endcase

        w_shift = wbs_dat_i >> {r_lane, 3'b000};
        case (r_f3)
            3'b000:  w_ld = {{24{w_shift[7]}},  w_shift[7:0]};
            3'b001:  w_ld = {{16{w_shift[15]}}, w_shift[15:0]};
            3'b100:  w_ld = {24'd0, w_shift[7:0]};
            3'b101:  w_ld = {16'd0, w_shift[15:0]};
            default: w_ld = wbs_dat_i;
        endcase

        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_state_nxt = S_BUS;
            S_BUS:   if (w_fault | w_ok) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_cnt <= '0; r_cyc <= 1'b0; r_we <= 1'b0; r_addr <= '0; r_sel <= 4'd0; r_dat <= 32'd0;
            r_ld <= 1'b0; r_f3 <= 3'd0; r_lane <= 2'd0; r_alu32 <= 32'd0; r_mrd <= '0;
        end else begin
            if (w_accept)                r_cnt <= '0;
            else if (r_state == S_BUS)   r_cnt <= r_cnt + 1'b1;
            if (w_start) begin
                r_cyc   <= 1'b1;
                r_we    <= mem_we_i;
                r_addr  <= {mem_alu_i[ADDR_W-1:2], 2'b00};
                r_sel   <= w_sel;
                r_dat   <= w_dat;
                r_ld    <= ~mem_we_i;
                r_f3    <= mem_funct3_i;
                r_lane  <= mem_alu_i[1:0];
                r_alu32 <= w_alu32;
                r_mrd   <= mem_rd_i;
            end else if (w_fault | w_ok) begin
                r_cyc   <= 1'b0;
            end
        end
    end

    // Result registers freeze while WB is stalling a valid result.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_valid <= 1'b0; r_out <= 32'd0; r_rd <= '0; r_pc <= 32'd0; r_exc <= 1'b0; r_code <= 4'd0;
        end else if (!(r_valid & mem_stall_i)) begin
            r_valid <= 1'b0;
            if (w_accept) r_pc <= mem_pc_i;
            if (w_accept & ~w_start) begin
                r_valid <= 1'b1;
                r_exc   <= w_trap;
                r_code  <= w_trap ? w_trap_code : 4'd0;
                r_out   <= (w_trap | ~mem_link_i) ? w_alu32 : mem_pc4_i;
                r_rd    <= w_trap ? '0 : mem_rd_i;
            end else if (w_fault) begin
                r_valid <= 1'b1;
                r_exc   <= 1'b1;
                r_code  <= r_ld ? 4'd5 : 4'd7;
                r_out   <= r_alu32;
                r_rd    <= '0;
            end else if (w_ok) begin
                r_valid <= 1'b1;
                r_exc   <= 1'b0;
                r_code  <= 4'd0;
                r_out   <= r_ld ? w_ld : 32'd0;
                r_rd    <= r_ld ? r_mrd : '0;
            end
        end
    end

    assign mem_valid_o    = r_valid;
    assign mem_out_o      = r_out;
    assign mem_rd_o       = r_rd;
    assign mem_pc_o       = r_pc;
    assign mem_exc_o      = r_exc;
    assign mem_exc_code_o = r_code;
    assign wbs_cyc_o      = r_cyc;
    assign wbs_stb_o      = r_cyc;
    assign wbs_we_o       = r_we;
    assign wbs_addr_o     = r_addr;
    assign wbs_sel_o      = r_sel;
    assign wbs_dat_o      = r_dat;

endmodule

`default_nettype wire
